// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA/ROL by up to 2^AMT_W-1 bits in steps of <= STEP_MAX.
// Optional SHIFT_SEQ_CLAMP_EN normalises the amount at acceptance (clamp to WIDTH, or mod WIDTH for ROL).
module shift_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int STEP_W = $clog2(STEP_MAX + 1);
  localparam logic [AMT_W-1:0] STEP_MAX_A = AMT_W'(STEP_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic [1:0]       mode_q;

  logic [AMT_W-1:0] amt_n;
  logic [WIDTH-1:0] src_data;
  logic [AMT_W-1:0] src_rem;
  logic [1:0]       src_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0] nxt_data;
  logic [AMT_W-1:0] nxt_rem;

  function automatic logic [WIDTH-1:0] do_step(input logic [WIDTH-1:0] d,
                                               input logic [STEP_W-1:0] s,
                                               input logic [1:0] m);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} << s;
    case (m)
      2'b00:   do_step = d << s;
      2'b01:   do_step = d >> s;
      2'b10:   do_step = WIDTH'($signed(d) >>> s);
      default: do_step = dd[2*WIDTH-1:WIDTH];
    endcase
  endfunction

  always_comb begin
    amt_n = in_amt;
`ifdef SHIFT_SEQ_CLAMP_EN
    if (in_mode == 2'b11)
      amt_n = in_amt % AMT_W'(WIDTH);
    else if (in_amt > AMT_W'(WIDTH))
      amt_n = AMT_W'(WIDTH);
`endif
  end

  // The acceptance edge already applies the first step, so latency is ceil(amt/STEP_MAX).
  always_comb begin
    src_data = (state == IDLE) ? in_data : data_q;
    src_rem  = (state == IDLE) ? amt_n   : rem_q;
    src_mode = (state == IDLE) ? in_mode : mode_q;
    step     = (src_rem > STEP_MAX_A) ? STEP_W'(STEP_MAX) : src_rem[STEP_W-1:0];
    nxt_data = do_step(src_data, step, src_mode);
    nxt_rem  = src_rem - AMT_W'(step);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      rem_q     <= '0;
      mode_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q   <= nxt_data;
          rem_q    <= nxt_rem;
          mode_q   <= in_mode;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (nxt_rem == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= nxt_data;
          rem_q  <= nxt_rem;
          if (nxt_rem == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed-vector bench for shift_seq_ctrl with hand-computed results and latencies.
module tb_shift_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [4:0] in_amt = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  shift_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected edges from acceptance to out_valid for the build being simulated.
  function automatic int exp_lat(input int amt, input logic [1:0] mode);
    int a;
    a = amt;
`ifdef SHIFT_SEQ_CLAMP_EN
    if (mode == 2'b11) a = amt % 8;
    else if (amt > 8) a = 8;
`else
    if (mode == 2'b11) a = amt;
`endif
    return (a == 0) ? 1 : (a + 6) / 7;
  endfunction

  // Present a request, wait for the result; leaves DUT in DONE with out_ready low.
  task automatic send(input logic [7:0] d, input logic [4:0] a, input logic [1:0] m,
                      output logic [7:0] od, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_data = d; in_amt = a; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = ~d; in_amt = 5'd1; in_mode = ~m;  // must not disturb the latched request
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    od = out_data;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [4:0] a;
    logic [1:0] m;
    logic [7:0] r;
  } vec_t;

  vec_t vt[$];
  logic [7:0] od;
  int lat;

  initial begin
    vt.push_back('{8'h3C, 5'd3,  2'b00, 8'hE0});
    vt.push_back('{8'hD0, 5'd10, 2'b10, 8'hFF});
    vt.push_back('{8'h8F, 5'd12, 2'b11, 8'hF8});
    vt.push_back('{8'h8F, 5'd3,  2'b11, 8'h7C});
    vt.push_back('{8'h81, 5'd7,  2'b01, 8'h01});
    vt.push_back('{8'h40, 5'd9,  2'b10, 8'h00});
    vt.push_back('{8'hFF, 5'd8,  2'b00, 8'h00});
    vt.push_back('{8'h81, 5'd8,  2'b11, 8'h81});
    vt.push_back('{8'h90, 5'd2,  2'b10, 8'hE4});

    // Reset state, with a handshake attempt that must be ignored.
    #12;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    foreach (vt[i]) begin
      send(vt[i].d, vt[i].a, vt[i].m, od, lat);
      chk($sformatf("vec%0d_data", i), {24'd0, od}, {24'd0, vt[i].r});
      chk($sformatf("vec%0d_lat", i), lat, exp_lat(vt[i].a, vt[i].m));
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      drain();
    end

    // SRL by 31 with long backpressure.
    send(8'hB1, 5'd31, 2'b01, od, lat);
    chk("srl31_data", {24'd0, od}, 32'h00);
    chk("srl31_lat", lat, exp_lat(31, 2'b01));
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", {24'd0, out_data}, 32'h00);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    drain();

    // Zero amount, then out_ready together with a new in_valid.
    send(8'h8F, 5'd0, 2'b00, od, lat);
    chk("zero_data", {24'd0, od}, 32'h8F);
    chk("zero_lat", lat, 1);
    in_data = 8'h80; in_amt = 5'd1; in_mode = 2'b01; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ovl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ovl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ovl_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovl2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ovl2_data", {24'd0, out_data}, 32'h40);
    drain();

    // Reset in the middle of a long SRA.
    in_data = 8'h80; in_amt = 5'd20; in_mode = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", {24'd0, out_data}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h01, 5'd4, 2'b00, od, lat);
    chk("post_rst_data", {24'd0, od}, 32'h10);
    chk("post_rst_lat", lat, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
